// File: rtl/pwm_if.sv
// Beat-stream bundle for the pointwise Montgomery multiplier: two lanes of operand
// pairs in, two lane results out, with valid and end-of-polynomial marker.
interface pwm_if #(
   parameter int unsigned DATA_WIDTH = 23
) ();

   logic                  in_en;
   logic [DATA_WIDTH-1:0] in [2][2];
   logic                  out_en;
   logic [DATA_WIDTH-1:0] out [2];
   logic                  out_last;

   modport master (
      output in_en,
      output in,
      input  out_en,
      input  out,
      input  out_last
   );

   modport slave (
      input  in_en,
      input  in,
      output out_en,
      output out,
      output out_last
   );

endinterface

// File: rtl/pwm.sv
// pwm: two-lane pointwise Montgomery multiplier, one 3-stage reduction group per lane.
// Macro PWM_STD_DOMAIN_EN appends a second group multiplying by R2 (standard-domain output).
module pwm #(
   parameter int unsigned DATA_WIDTH = 23,
   parameter int unsigned Q          = 8380417,
   parameter int unsigned QINV       = 8380415,
   parameter int unsigned R2         = 49145,
   parameter int unsigned N          = 256
) (
   input  logic clk,
   input  logic rst,
   pwm_if.slave bus
);

   localparam int unsigned W = DATA_WIDTH;
`ifdef PWM_STD_DOMAIN_EN
   localparam int unsigned NumGroups = 2;
`else
   localparam int unsigned NumGroups = 1;
`endif
   localparam int unsigned L     = 3 * NumGroups;
   localparam int unsigned Beats = N / 2;
   localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

   localparam logic [W-1:0]    QinvW  = W'(QINV);
   localparam logic [W-1:0]    R2W    = W'(R2);
   localparam logic [2*W:0]    QExt   = (2*W+1)'(Q);
   localparam logic [W:0]      QT     = (W+1)'(Q);
   localparam logic [CntW-1:0] CntMax = CntW'(Beats - 1);

   logic [2*W-1:0] p1_q [NumGroups][2];
   logic [2*W-1:0] p1_d [NumGroups][2];
   logic [2*W-1:0] p2_q [NumGroups][2];
   logic [2*W-1:0] p2_d [NumGroups][2];
   logic [W-1:0]   m2_q [NumGroups][2];
   logic [W-1:0]   m2_d [NumGroups][2];
   logic [W-1:0]   r_q  [NumGroups][2];
   logic [W-1:0]   r_d  [NumGroups][2];

   logic [L-1:0]    vld_q, vld_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin : p_pipe
      logic           grp_vld;
      logic [W-1:0]   op_a;
      logic [W-1:0]   op_b;
      logic [2*W:0]   sum;
      logic [W:0]     t;
      int             prev;
      grp_vld = 1'b0;
      op_a    = '0;
      op_b    = '0;
      sum     = '0;
      t       = '0;
      prev    = 0;
      p1_d    = p1_q;
      p2_d    = p2_q;
      m2_d    = m2_q;
      r_d     = r_q;
      vld_d   = {vld_q[L-2:0], bus.in_en};
      for (int g = 0; g < NumGroups; g++) begin
         prev    = (g == 0) ? 0 : g - 1;
         grp_vld = (g == 0) ? bus.in_en : vld_q[3*prev+2];
         for (int l = 0; l < 2; l++) begin
            // Later groups fold the previous result back by R2 to leave the Montgomery domain.
            op_a = (g == 0) ? bus.in[l][0] : r_q[prev][l];
            op_b = (g == 0) ? bus.in[l][1] : R2W;
            if (grp_vld) begin
               p1_d[g][l] = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
            end
            if (vld_q[3*g]) begin
               p2_d[g][l] = p1_q[g][l];
               m2_d[g][l] = p1_q[g][l][W-1:0] * QinvW;
            end
            if (vld_q[3*g+1]) begin
               // Full 2W+1 bits: p + m*Q can carry out of 2W before the shift.
               sum = {1'b0, p2_q[g][l]} + ({{(W+1){1'b0}}, m2_q[g][l]} * QExt);
               t   = sum[2*W:W];
               r_d[g][l] = (t >= QT) ? W'(t - QT) : t[W-1:0];
            end
         end
      end
   end

   always_comb begin : p_cnt
      cnt_d = cnt_q;
      if (vld_q[L-1]) begin
         cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin : p_regs
      if (rst) begin
         vld_q <= '0;
         cnt_q <= '0;
         for (int g = 0; g < NumGroups; g++) begin
            for (int l = 0; l < 2; l++) begin
               p1_q[g][l] <= '0;
               p2_q[g][l] <= '0;
               m2_q[g][l] <= '0;
               r_q[g][l]  <= '0;
            end
         end
      end else begin
         vld_q <= vld_d;
         cnt_q <= cnt_d;
         p1_q  <= p1_d;
         p2_q  <= p2_d;
         m2_q  <= m2_d;
         r_q   <= r_d;
      end
   end

   always_comb begin : p_out
      bus.out_en   = vld_q[L-1];
      bus.out_last = vld_q[L-1] && (cnt_q == CntMax);
      for (int l = 0; l < 2; l++) begin
         bus.out[l] = r_q[NumGroups-1][l];
      end
   end

endmodule

// File: tb/tb_pwm.sv
// Randomised scoreboard bench for pwm: modular-arithmetic reference model feeds a queue,
// a negedge monitor pops and checks data, out_last placement and latency.
module tb_pwm;

   localparam int unsigned W     = 23;
   localparam longint unsigned Q = 8380417;
   localparam int unsigned N     = 256;
   localparam int unsigned BEATS = N / 2;
`ifdef PWM_STD_DOMAIN_EN
   localparam int unsigned L = 6;
`else
   localparam int unsigned L = 3;
`endif

   typedef struct {
      longint unsigned e0;
      longint unsigned e1;
      bit              last;
      int unsigned     cyc;
   } exp_t;

   logic clk;
   logic rst;
   pwm_if #(.DATA_WIDTH(W)) bus ();

   pwm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned     total;
   int unsigned     bad;
   int unsigned     cyc;
   int unsigned     mcnt;
   bit              mon_en;
   longint unsigned held0, held1;
   longint unsigned rinv;
   exp_t            sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   function automatic void check(string name, longint unsigned got, longint unsigned want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endfunction

   function automatic longint unsigned modmul(longint unsigned a, longint unsigned b);
      return ((a % Q) * (b % Q)) % Q;
   endfunction

   function automatic longint unsigned modpow(longint unsigned b, longint unsigned e);
      longint unsigned r = 1;
      longint unsigned x = b % Q;
      while (e != 0) begin
         if (e[0]) r = modmul(r, x);
         x = modmul(x, x);
         e = e >> 1;
      end
      return r;
   endfunction

   function automatic longint unsigned model(longint unsigned a, longint unsigned b);
`ifdef PWM_STD_DOMAIN_EN
      return modmul(a, b);
`else
      return modmul(modmul(a, b), rinv);
`endif
   endfunction

   // Monitor: every out_en pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_en) begin
            if (sb.size() == 0) begin
               check("unexpected_out_en", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("lane0", bus.out[0], e.e0);
               check("lane1", bus.out[1], e.e1);
               check("out_last", bus.out_last, e.last);
               check("latency", cyc - e.cyc, L);
               check("lane0_lt_q", (bus.out[0] < Q), 1);
            end
            held0 = bus.out[0];
            held1 = bus.out[1];
         end else begin
            if (bus.out_last) check("last_without_en", bus.out_last, 0);
            check("hold0", bus.out[0], held0);
            check("hold1", bus.out[1], held1);
         end
      end
   end

   task automatic idle();
      bus.in_en = 1'b0;
      for (int l = 0; l < 2; l++) begin
         bus.in[l][0] = W'($urandom);
         bus.in[l][1] = W'($urandom);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(longint unsigned a0, longint unsigned b0,
                       longint unsigned a1, longint unsigned b1);
      exp_t e;
      bus.in_en    = 1'b1;
      bus.in[0][0] = W'(a0);
      bus.in[0][1] = W'(b0);
      bus.in[1][0] = W'(a1);
      bus.in[1][1] = W'(b1);
      e.e0   = model(a0, b0);
      e.e1   = model(a1, b1);
      e.last = (mcnt == BEATS - 1);
      e.cyc  = cyc;
      mcnt   = (mcnt + 1) % BEATS;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_en = 1'b0;
   endtask

   task automatic send_rand();
      send($urandom_range(Q - 1), $urandom_range(Q - 1),
           $urandom_range(Q - 1), $urandom_range(Q - 1));
   endtask

   task automatic send_poly(int unsigned duty);
      for (int i = 0; i < BEATS; i++) begin
         while ($urandom_range(99) >= duty) idle();
         send_rand();
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * L + 10 && sb.size() != 0; i++) idle();
      check("drain", sb.size(), 0);
      for (int i = 0; i < 4; i++) idle();
   endtask

   // Reset with in_en also high: that beat is dropped along with everything in flight.
   task automatic reset_pulse();
      rst       = 1'b1;
      bus.in_en = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      mcnt      = 0;
      held0     = 0;
      held1     = 0;
      rst       = 1'b0;
      bus.in_en = 1'b0;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      cyc    = 0;
      mcnt   = 0;
      mon_en = 1'b0;
      held0  = 0;
      held1  = 0;
      rinv   = modpow(64'd1 << W, Q - 2);
      rst    = 1'b1;
      bus.in_en = 1'b0;
      for (int l = 0; l < 2; l++) begin
         bus.in[l][0] = '0;
         bus.in[l][1] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      check("rst_out_en", bus.out_en, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_out0", bus.out[0], 0);
      check("rst_out1", bus.out[1], 0);

      // Directed: identity (8191 = R mod Q), zero, boundary, small std-domain values.
      send(8191, 12345, 8191, Q - 1);
      for (int i = 0; i < 5; i++) idle();
      send(0, Q - 1, Q - 1, Q - 1);
      send(2, 3, Q - 1, 0);
      send(Q - 1, Q - 1, 2, 3);
      drain();

      // Two back-to-back polynomials with ~60% duty.
      reset_pulse();
      send_poly(60);
      send_poly(60);
      drain();

      // Reset while beats are in flight, then a fresh polynomial.
      send_rand();
      send_rand();
      send_rand();
      reset_pulse();
      check("post_rst_out0", bus.out[0], 0);
      check("post_rst_out1", bus.out[1], 0);
      check("post_rst_en", bus.out_en, 0);
      for (int i = 0; i < L + 3; i++) idle();
      send_poly(60);
      drain();

      // Random soak with varying duty.
      for (int p = 0; p < 160; p++) send_poly($urandom_range(95, 40));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
